traffic_client: RTL and testbench

Parametrised traffic-generating endpoint for the torus NoC, attached to one router's local port. It injects `N_PACKETS` packets, shaped by an internal token-bucket regulator, to pseudo-random destinations across `NUM_VC` virtual channels using a valid/ack handshake. It also sinks ejected traffic, counting packets and flagging misrouted ones, and raises `done` once all of its own traffic has been accepted by the router.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/token_bucket.sv | 35 +++
 rtl/traffic_client.sv | 104 ++++++++++
 tb/tb_traffic_client.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared constants, FSM state type and destination helpers for NoC traffic clients
package noc_pkg;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} inj_state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic int dest_x(input logic [15:0] s, input int xw, input int yw, input int x, input int y);
      int dx;
      int dy;
      dx = int'(s) & ((1 << xw) - 1);
      dy = (int'(s) >> xw) & ((1 << yw) - 1);
      return (dx == x && dy == y) ? (dx ^ 1) : dx;
   endfunction

endpackage

// File: rtl/token_bucket.sv
// token_bucket: one token per RATE cycles, bucket depth SIGMA, starts full
module token_bucket #(
   parameter int RATE  = 20,
   parameter int SIGMA = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic consume,
   output logic token_available
);

   localparam int CW = $clog2(RATE + 1);
   localparam int TW = $clog2(SIGMA + 1);

   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_tokens;
   logic          w_refill;

   assign w_refill        = (r_cnt == CW'(RATE - 1));
   assign token_available = (r_tokens != '0);

   // refill counter wraps every RATE cycles; a coinciding refill and consume cancel out
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cnt    <= '0;
         r_tokens <= TW'(SIGMA);
      end else begin
         r_cnt <= w_refill ? '0 : r_cnt + CW'(1);
         if (w_refill && !consume && r_tokens != TW'(SIGMA))
            r_tokens <= r_tokens + TW'(1);
         else if (consume && !w_refill)
            r_tokens <= r_tokens - TW'(1);
      end

endmodule

// File: rtl/traffic_client.sv
// traffic_client: rate-shaped packet injector and ejection checker for one torus NoC router port
module traffic_client
   import noc_pkg::*;
#(
   parameter int X_W       = 2,
   parameter int Y_W       = 2,
   parameter int X         = 0,
   parameter int Y         = 0,
   parameter int VC_W      = 3,
   parameter int NUM_VC    = 4,
   parameter int D_W       = 32,
   parameter int N_PACKETS = 128,
   parameter int RATE      = 20,
   parameter int SIGMA     = 3
) (
   input  logic            clk,
   input  logic            rst,
   output logic            i_v,
   input  logic            i_ack,
   output logic [VC_W-1:0] i_vc,
   output logic [X_W-1:0]  i_x,
   output logic [Y_W-1:0]  i_y,
   output logic [D_W-1:0]  i_data,
   input  logic            o_v,
   input  logic [X_W-1:0]  o_x,
   input  logic [Y_W-1:0]  o_y,
   input  logic [D_W-1:0]  o_data,
   output logic            done,
   output logic [31:0]     rx_count,
   output logic            rx_err
);

   localparam int SEQ_W = $clog2(N_PACKETS + 1);
   localparam int PAD   = D_W - X_W - Y_W - SEQ_W;
   localparam logic [SEQ_W-1:0] N_ALL = SEQ_W'(N_PACKETS);

   inj_state_t       r_state;
   inj_state_t       w_next;
   logic [SEQ_W-1:0] r_sent;
   logic [15:0]      r_lfsr;
   logic [VC_W-1:0]  r_vc_cnt;
   logic             w_tok;
   logic             w_launch;
   logic [D_W-1:0]   w_data;
   logic             w_unused;

   assign i_v      = (r_state == WAIT_ACK);
   assign done     = (r_state == DONE);
   assign w_data   = D_W'({X_W'(X), Y_W'(Y), r_sent}) << PAD;
   assign w_unused = ^o_data;

   token_bucket #(.RATE(RATE), .SIGMA(SIGMA)) u_bucket (
      .clk             (clk),
      .rst             (rst),
      .consume         (w_launch),
      .token_available (w_tok)
   );

   // injection state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;

   // launch when a token is free, packets remain and the output slot is empty or being acked
   always_comb begin
      w_launch = w_tok && (r_sent != N_ALL) && (r_state != WAIT_ACK || i_ack);
      w_next   = r_state;
      if (w_launch)
         w_next = WAIT_ACK;
      else if (r_state != WAIT_ACK || i_ack)
         w_next = (r_sent == N_ALL) ? DONE : IDLE;
   end

   // packet fields load only on launch, so they hold while the router withholds ack
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_sent   <= '0;
         r_lfsr   <= LFSR_SEED;
         r_vc_cnt <= '0;
         i_vc     <= '0;
         i_x      <= '0;
         i_y      <= '0;
         i_data   <= '0;
      end else if (w_launch) begin
         i_vc     <= r_vc_cnt;
         i_x      <= X_W'(dest_x(r_lfsr, X_W, Y_W, X, Y));
         i_y      <= r_lfsr[X_W+Y_W-1:X_W];
         i_data   <= w_data;
         r_sent   <= r_sent + SEQ_W'(1);
         r_lfsr   <= lfsr_next(r_lfsr);
         r_vc_cnt <= (r_vc_cnt == VC_W'(NUM_VC - 1)) ? '0 : r_vc_cnt + VC_W'(1);
      end

   // ejection side: count every arrival and latch any packet not addressed to us
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rx_count <= '0;
         rx_err   <= 1'b0;
      end else if (o_v) begin
         rx_count <= rx_count + 32'd1;
         if (o_x != X_W'(X) || o_y != Y_W'(Y)) rx_err <= 1'b1;
      end

endmodule

// File: tb/tb_traffic_client.sv
// tb_traffic_client: randomized checks of traffic_client against a behavioural model
module tb_traffic_client;

   localparam int RATE  = 20;
   localparam int SIGMA = 3;
   localparam int NV    = 4;
   localparam int N0    = 128;
   localparam int N2    = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
   logic        ov = 1'b0;
   logic [1:0]  ox = '0, oy = '0;
   logic [31:0] od = '0;

   logic        v0, v1, v2, done0, done1, done2, err0, err1, err2;
   logic [2:0]  vc0, vc1, vc2;
   logic [1:0]  x0, x1, x2, y0, y1, y2;
   logic [31:0] d0, d1, d2, rxc0, rxc1, rxc2;

   int n_chk = 0;
   int n_fail = 0;

   logic [15:0] lt [0:N2];

   int          m_edge, m_tok, m_sent, m_vc, m_x, m_y, m_rx;
   bit          m_v, m_done, m_err;
   logic [31:0] m_d;

   always #5 clk = ~clk;

   traffic_client #(.X(0), .Y(0), .N_PACKETS(N0), .RATE(RATE), .SIGMA(SIGMA)) u0 (
      .clk(clk), .rst(rst), .i_v(v0), .i_ack(ack0), .i_vc(vc0), .i_x(x0), .i_y(y0), .i_data(d0),
      .o_v(ov), .o_x(ox), .o_y(oy), .o_data(od), .done(done0), .rx_count(rxc0), .rx_err(err0));

   traffic_client #(.X(0), .Y(0), .N_PACKETS(4), .RATE(RATE), .SIGMA(SIGMA)) u1 (
      .clk(clk), .rst(rst), .i_v(v1), .i_ack(ack1), .i_vc(vc1), .i_x(x1), .i_y(y1), .i_data(d1),
      .o_v(ov), .o_x(ox), .o_y(oy), .o_data(od), .done(done1), .rx_count(rxc1), .rx_err(err1));

   traffic_client #(.X(1), .Y(2), .N_PACKETS(N2), .RATE(1), .SIGMA(SIGMA)) u2 (
      .clk(clk), .rst(rst), .i_v(v2), .i_ack(ack2), .i_vc(vc2), .i_x(x2), .i_y(y2), .i_data(d2),
      .o_v(ov), .o_x(ox), .o_y(oy), .o_data(od), .done(done2), .rx_count(rxc2), .rx_err(err2));

   function automatic int exp_x(int n, int own_x, int own_y);
      int x = int'(lt[n][1:0]);
      int y = int'(lt[n][3:2]);
      return (x == own_x && y == own_y) ? (x ^ 1) : x;
   endfunction

   function automatic void model_reset();
      m_edge = 0; m_tok = SIGMA; m_sent = 0; m_vc = 0; m_x = 0; m_y = 0; m_rx = 0;
      m_v = 0; m_done = 0; m_err = 0; m_d = '0;
   endfunction

   task automatic tick();
      bit launch, refill;
      @(posedge clk);
      m_edge++;
      refill = (m_edge % RATE) == 0;
      launch = m_tok > 0 && m_sent < N0 && (!m_v || ack0);
      if (launch) begin
         m_vc = m_sent % NV;
         m_x  = exp_x(m_sent, 0, 0);
         m_y  = int'(lt[m_sent][3:2]);
         m_d  = 32'(m_sent) << 20;
         m_sent++;
         m_v = 1;
      end else if (ack0) m_v = 0;
      if (!m_v && m_sent == N0) m_done = 1;
      if (refill && !launch) m_tok = (m_tok < SIGMA) ? m_tok + 1 : SIGMA;
      else if (launch && !refill) m_tok--;
      if (ov) begin
         m_rx++;
         if (ox != 2'd0 || oy != 2'd0) m_err = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; ack0 = 0; ack1 = 0; ack2 = 0; ov = 0; ox = '0; oy = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #23;
      n_chk++;
      if ({v0, vc0, x0, y0, d0, done0, rxc0, err0} !== '0) begin
         n_fail++; $display("FAIL reset_u0 got %h want 0", {v0, vc0, x0, y0, d0, done0, rxc0, err0});
      end
      n_chk++;
      if ({v1, vc1, x1, y1, d1, done1, rxc1, err1} !== '0) begin
         n_fail++; $display("FAIL reset_u1 got %h want 0", {v1, vc1, x1, y1, d1, done1, rxc1, err1});
      end
      n_chk++;
      if ({v2, vc2, x2, y2, d2, done2, rxc2, err2} !== '0) begin
         n_fail++; $display("FAIL reset_u2 got %h want 0", {v2, vc2, x2, y2, d2, done2, rxc2, err2});
      end
   endtask

   task automatic test_burst();
      int cyc[$];
      int vcs[$];
      int seqs[$];
      int want_c[5] = '{1, 2, 3, 21, 41};
      int want_vc[5] = '{0, 1, 2, 3, 0};
      do_reset();
      ack0 = 1;
      for (int c = 1; c <= 45; c++) begin
         tick();
         n_chk++;
         if ({v0, vc0, x0, y0, d0, done0} !== {m_v, 3'(m_vc), 2'(m_x), 2'(m_y), m_d, m_done}) begin
            n_fail++;
            $display("FAIL burst cyc %0d got %h want %h", c, {v0, vc0, x0, y0, d0, done0},
                     {m_v, 3'(m_vc), 2'(m_x), 2'(m_y), m_d, m_done});
         end
         if (v0) begin cyc.push_back(c); vcs.push_back(int'(vc0)); seqs.push_back(int'(d0[27:20])); end
      end
      n_chk++;
      if (cyc.size() != 5) begin n_fail++; $display("FAIL burst_count got %0d want 5", cyc.size()); end
      for (int i = 0; i < 5 && i < cyc.size(); i++) begin
         n_chk++;
         if (cyc[i] != want_c[i] || vcs[i] != want_vc[i] || seqs[i] != i) begin
            n_fail++;
            $display("FAIL burst_pkt %0d got cyc %0d vc %0d seq %0d want cyc %0d vc %0d seq %0d",
                     i, cyc[i], vcs[i], seqs[i], want_c[i], want_vc[i], i);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      ack0 = 0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         n_chk++;
         if ({v0, vc0, x0, y0, d0} !== {1'b1, 3'd0, 2'd1, 2'd0, 32'd0}) begin
            n_fail++; $display("FAIL hold cyc %0d got %h want %h", c, {v0, vc0, x0, y0, d0}, {1'b1, 3'd0, 2'd1, 2'd0, 32'd0});
         end
      end
      ack0 = 1;
      tick();
      ack0 = 0;
      n_chk++;
      if ({v0, vc0, x0, y0, d0} !== {m_v, 3'(m_vc), 2'(m_x), 2'(m_y), m_d} || d0[27:20] !== 8'd1) begin
         n_fail++; $display("FAIL hold_release got %h want %h", {v0, vc0, x0, y0, d0}, {m_v, 3'(m_vc), 2'(m_x), 2'(m_y), m_d});
      end
      tick();
      n_chk++;
      if ({v0, vc0} !== 4'b1001) begin
         n_fail++; $display("FAIL hold_next got %b want 1001", {v0, vc0});
      end
   endtask

   task automatic test_rx();
      do_reset();
      ov = 1; ox = 0; oy = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_chk++;
         if ({rxc0, err0} !== {32'(k), 1'b0}) begin
            n_fail++; $display("FAIL rx_good %0d got %0d/%b want %0d/0", k, rxc0, err0, k);
         end
      end
      ox = 2'd1;
      tick();
      ov = 0; ox = 0;
      n_chk++;
      if ({rxc0, err0} !== {32'd6, 1'b1}) begin
         n_fail++; $display("FAIL rx_bad got %0d/%b want 6/1", rxc0, err0);
      end
      repeat (5) tick();
      n_chk++;
      if ({rxc0, err0} !== {32'd6, 1'b1}) begin
         n_fail++; $display("FAIL rx_sticky got %0d/%b want 6/1", rxc0, err0);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 1; c <= 3000; c++) begin
         ack0 = ($urandom_range(0, 3) != 0);
         ov   = ($urandom_range(0, 2) == 0);
         ox   = ($urandom_range(0, 199) == 0) ? 2'd2 : 2'd0;
         oy   = 2'd0;
         tick();
         n_chk++;
         if ({v0, vc0, x0, y0, d0, done0, rxc0, err0} !==
             {m_v, 3'(m_vc), 2'(m_x), 2'(m_y), m_d, m_done, 32'(m_rx), m_err}) begin
            n_fail++;
            $display("FAIL random cyc %0d got %h want %h", c, {v0, vc0, x0, y0, d0, done0, rxc0, err0},
                     {m_v, 3'(m_vc), 2'(m_x), 2'(m_y), m_d, m_done, 32'(m_rx), m_err});
         end
      end
      ov = 0; ack0 = 1;
      repeat (3) tick();
      n_chk++;
      if ({done0, v0} !== 2'b10) begin
         n_fail++; $display("FAIL random_done got %b want 10", {done0, v0});
      end
   endtask

   task automatic test_done();
      int hs = 0;
      do_reset();
      ack1 = 1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         n_chk++;
         if (done1 !== (hs == 4)) begin
            n_fail++; $display("FAIL done cyc %0d got %b want %b", c, done1, hs == 4);
         end
         if (v1) hs++;
      end
      n_chk++;
      if (hs != 4 || done1 !== 1'b1) begin
         n_fail++; $display("FAIL done_total got %0d/%b want 4/1", hs, done1);
      end
   endtask

   task automatic test_self_avoid();
      int hs = 0;
      logic [31:0] ed;
      do_reset();
      for (int c = 0; c < 4000 && hs < N2; c++) begin
         ack2 = $urandom_range(0, 1);
         if (v2 && ack2) begin
            ed = (32'd6 << 28) | (32'(hs) << 18);
            n_chk++;
            if ({x2, y2, d2} !== {2'(exp_x(hs, 1, 2)), lt[hs][3:2], ed} || {x2, y2} == 4'b0110 || d2[31:28] !== 4'b0110) begin
               n_fail++;
               $display("FAIL avoid pkt %0d got %h want %h", hs, {x2, y2, d2}, {2'(exp_x(hs, 1, 2)), lt[hs][3:2], ed});
            end
            hs++;
         end
         @(posedge clk); #1;
      end
      ack2 = 0;
      n_chk++;
      if (hs != N2) begin n_fail++; $display("FAIL avoid_timeout got %0d want %0d", hs, N2); end
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({done2, v2} !== 2'b10) begin
         n_fail++; $display("FAIL avoid_done got %b want 10", {done2, v2});
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      ack0 = 1; ov = 1;
      tick();
      tick();
      ov = 0;
      #3 rst = 1'b0;
      #1;
      n_chk++;
      if ({v0, vc0, x0, y0, d0, done0, rxc0, err0} !== '0) begin
         n_fail++; $display("FAIL async_reset got %h want 0", {v0, vc0, x0, y0, d0, done0, rxc0, err0});
      end
      @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      tick();
      n_chk++;
      if ({v0, vc0, x0, y0, d0} !== {1'b1, 3'd0, 2'd1, 2'd0, 32'd0}) begin
         n_fail++; $display("FAIL async_restart got %h want %h", {v0, vc0, x0, y0, d0}, {1'b1, 3'd0, 2'd1, 2'd0, 32'd0});
      end
   endtask

   initial begin
      lt[0] = 16'hACE1;
      for (int i = 1; i <= N2; i++)
         lt[i] = {lt[i-1][14:0], lt[i-1][15] ^ lt[i-1][13] ^ lt[i-1][12] ^ lt[i-1][10]};
      model_reset();
      test_reset();
      test_burst();
      test_hold();
      test_rx();
      test_random();
      test_done();
      test_self_avoid();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
